// File: rtl/divider_pkg.sv
// Shared ALU definitions for the divider: widths, flag bit positions and FSM encodings.
package divider_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int FLAGS_W    = 3;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_DIVZ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2,
    ST_FIXUP  = 2'd3
  } state_e;

  function automatic logic [FLAGS_W-1:0] make_flags(input logic zero,
                                                    input logic neg,
                                                    input logic divz);
    logic [FLAGS_W-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = zero;
    f[FLAG_NEG]  = neg;
    f[FLAG_DIVZ] = divz;
    return f;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module divider_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_WIDTH = DIVISOR_W
) (
  input  logic [DIVISOR_WIDTH-1:0] rem_in,
  input  logic                     bit_in,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH-1:0] rem_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0]   trial;
  logic [DIVISOR_WIDTH-1:0] diff;

  // The difference only matters when trial >= divisor, where it always fits the narrow width.
  always_comb begin
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {1'b0, divisor});
    diff    = trial[DIVISOR_WIDTH-1:0] - divisor;
    rem_out = q_bit ? diff : trial[DIVISOR_WIDTH-1:0];
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider with tri-state result/flag outputs.
// Define DIVIDER_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic [DIVIDEND_WIDTH-1:0] primary_operand,
  input  logic [DIVISOR_WIDTH-1:0]  secondary_operand,
  input  logic                      start,
  input  logic                      oe,
  output logic                      busy,
  output logic                      done,
  output wire logic [FLAGS_W-1:0]        flags,
  output wire logic [DIVIDEND_WIDTH-1:0] div_out,
  output wire logic [DIVISOR_WIDTH-1:0]  rem_out
);

  localparam int CW = $clog2(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDEND_WIDTH - 1);

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIVISOR_WIDTH-1:0]  prem_q, prem_d;
  logic [DIVISOR_WIDTH-1:0]  dsr_q, dsr_d;
  logic                      divz_q, divz_d;
  logic [DIVIDEND_WIDTH-1:0] quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  logic [FLAGS_W-1:0]        flags_q, flags_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef DIVIDER_SIGNED_EN
  logic                      qneg_q, qneg_d;
  logic                      rneg_q, rneg_d;
`endif

  logic [DIVISOR_WIDTH-1:0]  step_rem;
  logic                      step_q;

  divider_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
    .rem_in  (prem_q),
    .bit_in  (dvd_q[DIVIDEND_WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // dvd_q doubles as the quotient accumulator: dividend bits shift out the top, quotient bits in the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    dsr_d   = dsr_q;
    divz_d  = divz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    flags_d = flags_q;
    done_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          prem_d = '0;
          divz_d = (secondary_operand == '0);
`ifdef DIVIDER_SIGNED_EN
          qneg_d = primary_operand[DIVIDEND_WIDTH-1] ^ secondary_operand[DIVISOR_WIDTH-1];
          rneg_d = primary_operand[DIVIDEND_WIDTH-1];
          dvd_d  = primary_operand[DIVIDEND_WIDTH-1] ? -primary_operand : primary_operand;
          dsr_d  = secondary_operand[DIVISOR_WIDTH-1] ? -secondary_operand : secondary_operand;
`else
          dvd_d  = primary_operand;
          dsr_d  = secondary_operand;
`endif
          if (secondary_operand == '0) begin
            dvd_d   = primary_operand;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIVIDE;
          end
        end
      end
      ST_DIVIDE: begin
        prem_d = step_rem;
        dvd_d  = {dvd_q[DIVIDEND_WIDTH-2:0], step_q};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
`ifdef DIVIDER_SIGNED_EN
          state_d = ST_FIXUP;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef DIVIDER_SIGNED_EN
      ST_FIXUP: begin
        if (qneg_q) dvd_d = -dvd_q;
        if (rneg_q) prem_d = -prem_q;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (divz_q) begin
          quot_d = '1;
          rem_d  = dvd_q[DIVISOR_WIDTH-1:0];
        end else begin
          quot_d = dvd_q;
          rem_d  = prem_q;
        end
        flags_d = make_flags(quot_d == '0, quot_d[DIVIDEND_WIDTH-1], divz_q);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DIVIDE) || (state_d == ST_FIXUP);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      dsr_q   <= '0;
      divz_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      dsr_q   <= dsr_d;
      divz_q  <= divz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign flags   = oe ? flags_q : 'z;
  assign div_out = oe ? quot_q : 'z;
  assign rem_out = oe ? rem_q : 'z;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes model results, a monitor checks them on done.
module tb_divider;

`ifdef DIVIDER_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic [2:0]  f;
    int          start_edge;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] primary_operand = '0;
  logic [7:0]  secondary_operand = '0;
  logic        start = 1'b0;
  logic        oe = 1'b1;
  logic        busy, done;
  wire  [2:0]  flags;
  wire  [15:0] div_out;
  wire  [7:0]  rem_out;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];

  divider dut (
    .clock             (clock),
    .nreset            (nreset),
    .primary_operand   (primary_operand),
    .secondary_operand (secondary_operand),
    .start             (start),
    .oe                (oe),
    .busy              (busy),
    .done              (done),
    .flags             (flags),
    .div_out           (div_out),
    .rem_out           (rem_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int se);
    exp_t e;
    int sa, sbv, qi, ri;
    e.start_edge = se;
    if (b == 8'd0) begin
      e.q = 16'hFFFF;
      e.r = a[7:0];
      e.lat = 1;
    end else if (SIGNED) begin
      sa  = $signed(a);
      sbv = $signed(b);
      qi  = sa / sbv;
      ri  = sa % sbv;
      e.q = qi[15:0];
      e.r = ri[7:0];
      e.lat = 18;
    end else begin
      e.q = a / {8'd0, b};
      e.r = 8'(a % {8'd0, b});
      e.lat = 17;
    end
    e.f = {(b == 8'd0), e.q[15], (e.q == 16'd0)};
    return e;
  endfunction

  // Drive a start for one cycle from an idle DUT and record the expected response.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    @(posedge clock); #1;
    primary_operand   = a;
    secondary_operand = b;
    start             = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    @(posedge clock); #1;
    start = 1'b0;
    primary_operand   = $urandom;
    secondary_operand = $urandom;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_done timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] z16;
    logic [7:0]  z8;
    logic [2:0]  z3;
    z16 = 'z;
    z8  = 'z;
    z3  = 'z;
    forever begin
      @(negedge clock);
      if (nreset && done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.start_edge, e.lat);
          if (oe) begin
            chk("div_out", {16'd0, div_out}, {16'd0, e.q});
            chk("rem_out", {24'd0, rem_out}, {24'd0, e.r});
            chk("flags", {29'd0, flags}, {29'd0, e.f});
          end else begin
            chk("div_out_z", {16'd0, div_out}, {16'd0, z16});
            chk("rem_out_z", {24'd0, rem_out}, {24'd0, z8});
            chk("flags_z", {29'd0, flags}, {29'd0, z3});
          end
        end
      end
    end
  end

  initial begin : stimulus
    exp_t        held;
    logic [15:0] z16;
    logic [15:0] a;
    logic [7:0]  b;
    z16 = 'z;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_div_out", {16'd0, div_out}, 32'd0);
    chk("reset_rem_out", {24'd0, rem_out}, 32'd0);
    chk("reset_flags", {29'd0, flags}, 32'd0);
    nreset = 1'b1;

    issue(16'd1000, 8'd7);
    chk("busy_running", {31'd0, busy}, {31'd0, 1'b1});
    wait_idle();
    issue(16'd5, 8'd10);        wait_idle();
    issue(16'hFFFF, 8'd1);      wait_idle();
    issue(16'h1234, 8'd0);      wait_idle();
    issue(16'hFF9C, 8'd7);      wait_idle();
    issue(16'h8000, 8'hFF);     wait_idle();
    issue(16'd0, 8'd3);         wait_idle();

    // A second start mid-division must be dropped.
    issue(16'd1000, 8'd7);
    repeat (3) @(posedge clock);
    #1;
    primary_operand   = 16'd50;
    secondary_operand = 8'd5;
    start             = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_drop", {31'd0, busy}, {31'd0, 1'b1});
    wait_idle();

    // Reset mid-division: abandon, no done, registers cleared.
    issue(16'd1000, 8'd7);
    repeat (5) @(posedge clock);
    #1;
    nreset = 1'b0;
    sb.delete();
    @(posedge clock); #1;
    nreset = 1'b1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_div_out", {16'd0, div_out}, 32'd0);
    chk("midreset_rem_out", {24'd0, rem_out}, 32'd0);
    chk("midreset_flags", {29'd0, flags}, 32'd0);
    repeat (25) @(posedge clock);

    // Output enable low across a whole division.
    oe = 1'b0;
    held = model(16'd12345, 8'd99, 0);
    issue(16'd12345, 8'd99);
    chk("oe_low_busy_div_out", {16'd0, div_out}, {16'd0, z16});
    wait_idle();
    chk("oe_low_after_div_out", {16'd0, div_out}, {16'd0, z16});
    oe = 1'b1;
    #1;
    chk("held_div_out", {16'd0, div_out}, {16'd0, held.q});
    chk("held_rem_out", {24'd0, rem_out}, {24'd0, held.r});
    chk("held_flags", {29'd0, flags}, {29'd0, held.f});

    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(a, b);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      wait_idle();
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
